// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Merges the ALU and LSU write-back streams into the single registered write
// port of the register file, and flags in-flight writes for hazard stalls.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   alu_valid_i/addr/data    single-cycle ALU write-back, always accepted
//   lsu_valid_i/ready_o      LSU write-back handshake (buffered in a FIFO)
//   lsu_addr_i/data_i        LSU destination and load data
//   rs1/rs2_addr_i           source registers read by issue
//   rs1/rs2_pend_o           a write to that source is still in flight
//   rd_wren_o/addr_o/data_o  registered register-file write port
module reg_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic              rd_wren_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_wren_q, rd_wren_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              lsu_accept;
  logic              push;
  logic              pop;
  logic              alu_win;
  logic [PTR_W-1:0]  offset;
  logic              entry_vld;

  assign lsu_ready_o = (cnt_q != CNT_W'(DEPTH));
  assign lsu_accept  = lsu_valid_i && lsu_ready_o;
  // x0 beats are acknowledged but never stored: writing x0 is a no-op.
  assign push        = lsu_accept && (lsu_addr_i != '0);
  // ALU writes to x0 count as idle so the FIFO may drain that cycle.
  assign alu_win     = alu_valid_i && (alu_addr_i != '0);
  assign pop         = !alu_win && (cnt_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_wren_d = alu_win || pop;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (alu_win) begin
      rd_addr_d = alu_addr_i;
      rd_data_d = alu_data_i;
    end else if (pop) begin
      rd_addr_d = mem_addr[rd_ptr_q];
      rd_data_d = mem_data[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_wren_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= lsu_addr_i;
      mem_data[wr_ptr_q] <= lsu_data_i;
    end
  end

  // An entry is live when its distance from the read pointer is below cnt.
  always_comb begin
    rs1_pend_o = rd_wren_q && (rd_addr_q == rs1_addr_i);
    rs2_pend_o = rd_wren_q && (rd_addr_q == rs2_addr_i);
    offset     = '0;
    entry_vld  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset    = PTR_W'(i) - rd_ptr_q;
      entry_vld = (CNT_W'(offset) < cnt_q);
      if (entry_vld && (mem_addr[i] == rs1_addr_i)) rs1_pend_o = 1'b1;
      if (entry_vld && (mem_addr[i] == rs2_addr_i)) rs2_pend_o = 1'b1;
    end
    if (rs1_addr_i == '0) rs1_pend_o = 1'b0;
    if (rs2_addr_i == '0) rs2_pend_o = 1'b0;
  end

  assign rd_wren_o = rd_wren_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed testbench for reg_wb_arbiter (DEPTH=2, ADDR_W=5, DATA_W=32).
module tb_reg_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_pend_o;
  logic        rs2_pend_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int total = 0;
  int bad   = 0;

  reg_wb_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_data_i  (lsu_data_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_pend_o  (rs1_pend_o),
    .rs2_pend_o  (rs2_pend_o),
    .rd_wren_o   (rd_wren_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid_i = v;
    alu_addr_i  = a;
    alu_data_i  = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lsu_valid_i = v;
    lsu_addr_i  = a;
    lsu_data_i  = d;
  endtask

  task automatic chk_rd(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".wren"}, 32'(rd_wren_o), 32'(w));
    chk({tag, ".addr"}, 32'(rd_addr_o), 32'(a));
    chk({tag, ".data"}, rd_data_o, d);
  endtask

  initial begin
    // Reset with junk on every input.
    rst_i = 1'b1;
    alu(1'b1, 5'd9, 32'h1111_2222);
    lsu(1'b1, 5'd4, 32'h3333_4444);
    rs1_addr_i = 5'd4;
    rs2_addr_i = 5'd9;
    step();
    step();
    chk_rd("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.ready", 32'(lsu_ready_o), 32'd1);
    chk("rst.pend1", 32'(rs1_pend_o), 32'd0);
    chk("rst.pend2", 32'(rs2_pend_o), 32'd0);
    alu(1'b0, 5'd0, 32'h0);
    lsu(1'b0, 5'd0, 32'h0);
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle.wren", 32'(rd_wren_o), 32'd0);
    end

    // ALU write x2.
    alu(1'b1, 5'd2, 32'h4444_4444);
    rs2_addr_i = 5'd2;
    step();
    alu(1'b0, 5'd0, 32'h0);
    chk_rd("alu", 1'b1, 5'd2, 32'h4444_4444);
    chk("alu.pend2", 32'(rs2_pend_o), 32'd1);
    step();
    chk_rd("alu.hold", 1'b0, 5'd2, 32'h4444_4444);
    chk("alu.pend2_clr", 32'(rs2_pend_o), 32'd0);
    rs2_addr_i = 5'd0;

    // LSU write x1, two cycles from acceptance.
    lsu(1'b1, 5'd1, 32'h1234_5678);
    rs1_addr_i = 5'd1;
    #1;
    chk("lsu.ready", 32'(lsu_ready_o), 32'd1);
    chk("lsu.pend_pre", 32'(rs1_pend_o), 32'd0);
    step();
    lsu(1'b0, 5'd0, 32'h0);
    chk("lsu.k_wren", 32'(rd_wren_o), 32'd0);
    chk("lsu.k_pend", 32'(rs1_pend_o), 32'd1);
    step();
    chk_rd("lsu.out", 1'b1, 5'd1, 32'h1234_5678);
    chk("lsu.out_pend", 32'(rs1_pend_o), 32'd1);
    step();
    chk("lsu.done_wren", 32'(rd_wren_o), 32'd0);
    chk("lsu.done_pend", 32'(rs1_pend_o), 32'd0);

    // Priority and backpressure.
    rs1_addr_i = 5'd7;
    alu(1'b1, 5'd3, 32'h33);
    lsu(1'b1, 5'd5, 32'hFFFF_FFFF);
    step();
    chk_rd("pri.e1", 1'b1, 5'd3, 32'h33);
    chk("pri.e1_ready", 32'(lsu_ready_o), 32'd1);
    alu(1'b1, 5'd4, 32'h44);
    lsu(1'b1, 5'd7, 32'hA5A5_A5A5);
    step();
    chk_rd("pri.e2", 1'b1, 5'd4, 32'h44);
    chk("pri.e2_ready", 32'(lsu_ready_o), 32'd0);
    chk("pri.e2_pend7", 32'(rs1_pend_o), 32'd1);
    alu(1'b1, 5'd5, 32'h55);
    lsu(1'b1, 5'd8, 32'h1);
    step();
    chk_rd("pri.e3", 1'b1, 5'd5, 32'h55);
    chk("pri.e3_ready", 32'(lsu_ready_o), 32'd0);
    alu(1'b1, 5'd6, 32'h66);
    step();
    chk_rd("pri.e4", 1'b1, 5'd6, 32'h66);
    chk("pri.e4_ready", 32'(lsu_ready_o), 32'd0);
    alu(1'b0, 5'd0, 32'h0);
    step();
    chk_rd("pri.e5", 1'b1, 5'd5, 32'hFFFF_FFFF);
    chk("pri.e5_ready", 32'(lsu_ready_o), 32'd1);
    step();
    lsu(1'b0, 5'd0, 32'h0);
    chk_rd("pri.e6", 1'b1, 5'd7, 32'hA5A5_A5A5);
    step();
    chk_rd("pri.e7", 1'b1, 5'd8, 32'h1);
    step();
    chk("pri.e8_wren", 32'(rd_wren_o), 32'd0);
    chk("pri.e8_ready", 32'(lsu_ready_o), 32'd1);

    // x0 writes: ALU x0 is idle (FIFO pops), LSU x0 is acknowledged, not stored.
    rs1_addr_i = 5'd0;
    alu(1'b1, 5'd10, 32'hA0);
    lsu(1'b1, 5'd9, 32'h99);
    step();
    chk_rd("x0.a", 1'b1, 5'd10, 32'hA0);
    alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    lsu(1'b1, 5'd0, 32'hCAFE_F00D);
    #1;
    chk("x0.ready", 32'(lsu_ready_o), 32'd1);
    step();
    alu(1'b0, 5'd0, 32'h0);
    lsu(1'b0, 5'd0, 32'h0);
    chk_rd("x0.pop", 1'b1, 5'd9, 32'h99);
    chk("x0.pend0", 32'(rs1_pend_o), 32'd0);
    step();
    chk_rd("x0.none", 1'b0, 5'd9, 32'h99);
    chk("x0.ready_after", 32'(lsu_ready_o), 32'd1);

    // Reset with a full FIFO, asserted mid-cycle.
    alu(1'b1, 5'd11, 32'hB1);
    lsu(1'b1, 5'd13, 32'hD13);
    step();
    alu(1'b1, 5'd12, 32'hB2);
    lsu(1'b1, 5'd14, 32'hD14);
    step();
    alu(1'b0, 5'd0, 32'h0);
    lsu(1'b0, 5'd0, 32'h0);
    rs1_addr_i = 5'd13;
    #1;
    chk("full.ready", 32'(lsu_ready_o), 32'd0);
    chk("full.pend13", 32'(rs1_pend_o), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    chk_rd("mrst", 1'b0, 5'd0, 32'h0);
    chk("mrst.ready", 32'(lsu_ready_o), 32'd1);
    chk("mrst.pend13", 32'(rs1_pend_o), 32'd0);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst.no_stale", 32'(rd_wren_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and writer for the single write port of `reg_file`. It merges two write-back sources into one registered `rd_wren`/`rd_addr`/`rd_data` stream:
- the single-cycle ALU path, which has priority and no backpressure;
- the multi-cycle load/store path, which is buffered in a small FIFO with a valid/ready handshake.

It also reports pending writes so the issue stage can stall on read-after-write hazards against `rs1`/`rs2`.

## Interface

Parameters:
- `DEPTH`, 2 — LSU skid FIFO entries; power of two, ≥2.
- `ADDR_W`, 5 — register address width.
- `DATA_W`, 32 — register data width.

Ports:
- `clk_i`  in  1  — clock; all state changes on the rising edge.
- `rst_i`  in  1  — reset, asynchronous, active-high.
- `alu_valid_i`  in  1  — ALU write-back request this cycle; always accepted.
- `alu_addr_i`  in  ADDR_W  — ALU destination register.
- `alu_data_i`  in  DATA_W  — ALU result.
- `lsu_valid_i`  in  1  — LSU write-back offered.
- `lsu_ready_o`  out  1  — LSU write-back accepted when `lsu_valid_i && lsu_ready_o` at the edge.
- `lsu_addr_i`  in  ADDR_W  — LSU destination register.
- `lsu_data_i`  in  DATA_W  — LSU load data.
- `rs1_addr_i`, `rs2_addr_i`  in  ADDR_W  — source registers being read by issue.
- `rs1_pend_o`, `rs2_pend_o`  out  1  — a write to that register is still in flight.
- `rd_wren_o`  out  1  — register-file write enable, registered.
- `rd_addr_o`  out  ADDR_W  — register-file write address, registered.
- `rd_data_o`  out  DATA_W  — register-file write data, registered.

## Operation

- **FIFO storage:** circular buffer of `DEPTH` entries holding {addr, data}.
  - Write and read pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Occupancy counter `cnt` ranges 0..DEPTH.
- **LSU handshake:**
  - `lsu_ready_o = (cnt != DEPTH)`, combinational from registered `cnt`.
  - An accepted LSU beat with addr ≠ 0 is pushed.
  - An accepted LSU beat with addr = 0 is consumed and discarded, with no push.
- **Arbitration** (evaluated each cycle, result registered at the edge):
  - If `alu_valid_i` and `alu_addr_i` ≠ 0: the output stage loads the ALU write, and the FIFO does not pop.
  - Else if `cnt` ≠ 0: pop the head into the output stage.
  - Else: output stage `rd_wren_o` = 0.
  - `alu_valid_i` with addr 0 counts as idle, so the FIFO may pop that cycle.
- **Idle output:** when `rd_wren_o` = 0, `rd_addr_o`/`rd_data_o` hold their last values.
- **Simultaneous events:**
  - Push and pop in the same cycle leave `cnt` unchanged.
  - A push when `cnt` = DEPTH cannot occur, because ready is low.
  - A pop never reads the entry being pushed in the same cycle. There is no FIFO bypass.
- **Pending flags:** `rsN_pend_o` = 1 when `rsN_addr_i` ≠ 0 and it matches either of:
  - the addr of any valid FIFO entry;
  - `rd_addr_o` while `rd_wren_o` = 1.
  - Pending flags are combinational.
- **Ordering:**
  - Writes reach the register file in grant order.
  - Upstream must not issue an ALU write to a register whose pend flag is set. The arbiter does not reorder or kill entries.

## Timing

- **Reset values:**
  - `rd_wren_o` = 0, `rd_addr_o` = 0, `rd_data_o` = 0.
  - `cnt` = 0 and both pointers = 0, so `lsu_ready_o` = 1 and `rs1_pend_o` = `rs2_pend_o` = 0.
- **Reset mid-operation:** asserting `rst_i` immediately clears the FIFO and the output stage. In-flight LSU data is dropped.
- **ALU latency:** `alu_valid_i` in cycle c gives `rd_wren_o` = 1 in cycle c+1. The register file commits at the end of c+1.
- **LSU latency:** beat accepted at edge k, ALU idle afterwards, gives `rd_wren_o` = 1 in the cycle after edge k+1 (2 cycles from acceptance).
- **Starvation:** each cycle of continuous ALU traffic delays an LSU entry by one cycle. There is no fairness guarantee.
- **Throughput:** at most one register write per cycle.
- **Ready after full:** `lsu_ready_o` rises in the cycle after the edge at which a full FIFO pops.

## Test plan

- **Reset:** assert `rst_i` with junk on all inputs -> `rd_wren_o` = 0, `rd_addr_o` = 0, `rd_data_o` = 0, `lsu_ready_o` = 1, both pend = 0. Release `rst_i`, idle 3 cycles -> `rd_wren_o` stays 0.
- **ALU write:** ALU write x2 = 0x44444444 -> next cycle `rd_wren_o` = 1, `rd_addr_o` = 2, `rd_data_o` = 0x44444444. Paired `reg_file` read of x2 then returns 0x44444444.
- **LSU write:** LSU write x1 = 0x12345678 with ALU idle -> accepted, `rs1_pend_o` = 1 for `rs1_addr_i` = 1 from the next cycle. Write appears 2 cycles after acceptance, and pend clears after that cycle.
- **Priority and backpressure:** ALU busy every cycle (x3..x6) while LSU offers x5 = 0xFFFFFFFF, x7 = 0xA5A5A5A5, x8 = 0x1 -> `lsu_ready_o` = 0 after 2 accepts. The ALU writes appear in order. Once the ALU stops, x5 then x7 drain, ready returns, and x8 follows.
- **x0 writes:** ALU x0 = 0xDEADBEEF and LSU x0 = 0xCAFEF00D -> no `rd_wren_o`, `cnt` unchanged, LSU beat acknowledged. `rs1_addr_i` = 0 never raises pend.
- **Reset with full FIFO:** FIFO full, then pulse `rst_i` mid-cycle -> outputs immediately return to reset values, and no stale write occurs afterward.
